// File: rtl/operand_issue_if.sv
// Bundle of handshake, issue-output and bypass/writeback signals around the operand issue stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface operand_issue_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] op_1;
  logic [WIDTH-1:0] op_2;
  logic [2:0]       rd;
  logic             ex_valid;
  logic [2:0]       ex_rd;
  logic [WIDTH-1:0] ex_result;
  logic             wb_en;
  logic [2:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;

  modport slave (
    input  in_valid, instr, out_ready,
    input  ex_valid, ex_rd, ex_result,
    input  wb_en, wb_addr, wb_data,
    output in_ready, out_valid, opcode, op_1, op_2, rd
  );

  modport master (
    output in_valid, instr, out_ready,
    output ex_valid, ex_rd, ex_result,
    output wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, opcode, op_1, op_2, rd
  );
endinterface

// File: rtl/operand_issue.sv
// Operand issue stage: register file read with EX and WB bypass, feeding a
// one-entry registered output toward the ALU under a valid/ready handshake.
module operand_issue #(
  parameter int WIDTH = 12,
  parameter int NREGS = 8
) (
  input logic           clk,
  input logic           rst,
  operand_issue_if.slave bus
);
  logic [WIDTH-1:0] rf [NREGS];

  logic             out_valid_reg;
  logic [2:0]       opcode_reg;
  logic [2:0]       rd_reg;
  logic [WIDTH-1:0] op_1_reg;
  logic [WIDTH-1:0] op_2_reg;

  logic [WIDTH-1:0] op_1_next;
  logic [WIDTH-1:0] op_2_next;
  logic             in_ready_int;
  logic             accept;

  // R0 is hardwired; only entries 1..NREGS-1 hold state.
  assign rf[0] = '0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_rf
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (bus.wb_en && (bus.wb_addr == 3'(gi))) begin
          entry_reg <= bus.wb_data;
        end
      end
      assign rf[gi] = entry_reg;
    end
  endgenerate

  function automatic logic [WIDTH-1:0] resolve(
    input logic [2:0]       rs,
    input logic             ex_v,
    input logic [2:0]       ex_r,
    input logic [WIDTH-1:0] ex_res,
    input logic             wb_e,
    input logic [2:0]       wb_a,
    input logic [WIDTH-1:0] wb_d,
    input logic [WIDTH-1:0] file_val
  );
    logic [WIDTH-1:0] val;
    if (rs == 3'd0)                     val = '0;
    else if (ex_v && (ex_r == rs))      val = ex_res;
    else if (wb_e && (wb_a == rs))      val = wb_d;
    else                                val = file_val;
    return val;
  endfunction

  always_comb begin
    op_1_next = resolve(bus.instr[5:3], bus.ex_valid, bus.ex_rd, bus.ex_result,
                        bus.wb_en, bus.wb_addr, bus.wb_data, rf[bus.instr[5:3]]);
    op_2_next = resolve(bus.instr[2:0], bus.ex_valid, bus.ex_rd, bus.ex_result,
                        bus.wb_en, bus.wb_addr, bus.wb_data, rf[bus.instr[2:0]]);
  end

  assign in_ready_int = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && in_ready_int;

  // Operands are captured only on accept, so a stall never refreshes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      opcode_reg    <= '0;
      rd_reg        <= '0;
      op_1_reg      <= '0;
      op_2_reg      <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      opcode_reg    <= bus.instr[11:9];
      rd_reg        <= bus.instr[8:6];
      op_1_reg      <= op_1_next;
      op_2_reg      <= op_2_next;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.opcode    = opcode_reg;
  assign bus.rd        = rd_reg;
  assign bus.op_1      = op_1_reg;
  assign bus.op_2      = op_2_reg;
endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter WIDTH, default 12, datapath width of register file, operands and result paths.
REQ-002 Parameter NREGS, default 8, number of architectural registers; register index width 3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream presents an instruction on instr.
REQ-006 in_ready  output  1  block accepts instr this cycle.
REQ-007 instr  input  12  [11:9] opcode, [8:6] rd, [5:3] rs1, [2:0] rs2.
REQ-008 out_valid  output  1  registered opcode/op_1/op_2/rd valid toward ALU stage.
REQ-009 out_ready  input  1  downstream ALU stage consumes the output this cycle.
REQ-010 opcode  output  3  registered ALU opcode, selects one of 8 ALU results.
REQ-011 op_1  output  WIDTH  registered first operand (value of rs1).
REQ-012 op_2  output  WIDTH  registered second operand (value of rs2).
REQ-013 rd  output  3  registered destination register index.
REQ-014 ex_valid  input  1  instruction in the EX/WB register has a result pending writeback.
REQ-015 ex_rd  input  3  destination of that pending instruction.
REQ-016 ex_result  input  WIDTH  ALU result of that pending instruction.
REQ-017 wb_en  input  1  register-file write strobe.
REQ-018 wb_addr  input  3  register-file write index.
REQ-019 wb_data  input  WIDTH  register-file write data.

Function
REQ-020 Internal register file SHALL hold NREGS entries of WIDTH bits; R0 SHALL always read 0 and ignore writes.
REQ-021 On rising edge with wb_en=1 and wb_addr!=0, entry wb_addr SHALL be loaded with wb_data.
REQ-022 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-023 Accept occurs when in_valid && in_ready; on accept, opcode/rd/op_1/op_2 SHALL be registered and out_valid set to 1 next cycle (latency 1).
REQ-024 If out_valid && out_ready && !in_valid, out_valid SHALL clear next cycle; data outputs may hold old values.
REQ-025 While out_valid && !out_ready, all outputs SHALL hold stable and no instruction SHALL be accepted.
REQ-026 Operand resolution per source rsX, highest priority first: rsX==0 -> 0; ex_valid && ex_rd==rsX && ex_rd!=0 -> ex_result; wb_en && wb_addr==rsX -> wb_data; else register-file entry.
REQ-027 Resolution SHALL use port values of the accept cycle only; operands SHALL NOT be refreshed while stalled.
REQ-028 Same-cycle accept and writeback to a source register SHALL yield the new wb_data (write-through bypass).
REQ-029 rs1==rs2 SHALL produce identical op_1 and op_2.
REQ-030 Simultaneous consume and accept (out_valid && out_ready && in_valid) SHALL replace outputs with no bubble; out_valid stays 1.
REQ-031 All arithmetic is absent; values pass unmodified at WIDTH bits; no sign or zero extension.

Reset
REQ-032 With rst=1 at a rising edge: out_valid=0, opcode=0, op_1=0, op_2=0, rd=0, all register-file entries=0.
REQ-033 rst SHALL take priority over accept and writeback in the same cycle; in-flight output is discarded.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-035 Reset then instr=0x0CA (op0,rd3,rs1=1,rs2=2), in_valid=1, out_ready=1 -> next cycle out_valid=1, opcode=0, rd=3, op_1=0, op_2=0.
REQ-036 wb_en=1, wb_addr=1, wb_data=0x004; next cycle accept instr rs1=1 -> op_1=0x004; accept in same cycle as write -> op_1=0x004 (bypass).
REQ-037 R1=0x004 in file, ex_valid=1, ex_rd=1, ex_result=0x320, wb_en=1, wb_addr=1, wb_data=0x3E0 at accept -> op_1=0x320 (EX priority).
REQ-038 Issue with out_ready=0 for 3 cycles -> outputs stable, in_ready=0, second instr not taken; out_ready=1 with in_valid=1 -> back-to-back issue, out_valid stays 1.
REQ-039 wb_en=1, wb_addr=0, wb_data=0xFFF then read rs1=0 -> op_1=0x000.
REQ-040 rst=1 while out_valid=1 and wb_en=1 -> next cycle out_valid=0, all outputs 0, written register reads 0.
